// File: rtl/color_wheel_sequencer_if.sv
// Control and PWM output bundle of the colour-wheel sequencer.
// The master side drives en; the slave side (the sequencer) drives everything else.
interface color_wheel_sequencer_if;
  logic       en;
  logic       RGB_R;
  logic       RGB_G;
  logic       RGB_B;
  logic [2:0] phase;
  logic       period_tick;

  modport master (
    output en,
    input  RGB_R,
    input  RGB_G,
    input  RGB_B,
    input  phase,
    input  period_tick
  );

  modport slave (
    input  en,
    output RGB_R,
    output RGB_G,
    output RGB_B,
    output phase,
    output period_tick
  );
endinterface

// File: rtl/color_wheel_sequencer.sv
// Three-channel RGB PWM generator that walks a six-phase HSV hue wheel.
// Duty values are reloaded only at PWM period boundaries, so pulses never glitch.
module color_wheel_sequencer #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned DUTY_STEP    = 12
) (
  input logic                    clk,
  input logic                    rst,
  color_wheel_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(PWM_INTERVAL + 1);

  localparam logic [CW-1:0] IVal    = CW'(PWM_INTERVAL);
  localparam logic [CW-1:0] SVal    = CW'(DUTY_STEP);
  localparam logic [CW-1:0] RampMax = CW'(PWM_INTERVAL - DUTY_STEP);
  localparam logic [CW-1:0] CntMax  = CW'(PWM_INTERVAL - 1);

  if (PWM_INTERVAL < 2) begin : g_bad_interval
    $error("PWM_INTERVAL must be at least 2");
  end
  if (DUTY_STEP == 0) begin : g_bad_step_zero
    $error("DUTY_STEP must be non-zero");
  end else if (PWM_INTERVAL % DUTY_STEP != 0) begin : g_bad_step_div
    $error("PWM_INTERVAL must be a multiple of DUTY_STEP");
  end

  typedef enum logic [2:0] {
    StPh0 = 3'd0,
    StPh1 = 3'd1,
    StPh2 = 3'd2,
    StPh3 = 3'd3,
    StPh4 = 3'd4,
    StPh5 = 3'd5
  } phase_e;

  phase_e        phase_q, phase_d;
  logic [CW-1:0] pwm_cnt_q;
  logic [CW-1:0] ramp_q, ramp_d;
  logic [CW-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic [CW-1:0] duty_r_d, duty_g_d, duty_b_d;
  logic [CW-1:0] rise, fall;
  logic          rgb_r_q, rgb_g_q, rgb_b_q;
  logic          period_tick;

  assign period_tick = (pwm_cnt_q == CntMax);

  // Hue advance: only evaluated on the last clock of a PWM period.
  always_comb begin
    phase_d = phase_q;
    ramp_d  = ramp_q;
    if (period_tick) begin
      case (phase_q)
        StPh0, StPh1, StPh2, StPh3, StPh4, StPh5: begin
          if (bus.en) begin
            if (ramp_q == RampMax) begin
              ramp_d  = '0;
              phase_d = (phase_q == StPh5) ? StPh0 : phase_e'(phase_q + 3'd1);
            end else begin
              ramp_d = ramp_q + SVal;
            end
          end
        end
        // Encodings 6 and 7 are unreachable; recover to the wheel start.
        default: begin
          phase_d = StPh0;
          ramp_d  = '0;
        end
      endcase
    end
  end

  assign rise = ramp_d;
  assign fall = IVal - ramp_d;

  // Duty map for the upcoming period, built from next-state phase and ramp.
  always_comb begin
    duty_r_d = IVal;
    duty_g_d = '0;
    duty_b_d = '0;
    case (phase_d)
      StPh0: begin duty_r_d = IVal; duty_g_d = rise; duty_b_d = '0;   end
      StPh1: begin duty_r_d = fall; duty_g_d = IVal; duty_b_d = '0;   end
      StPh2: begin duty_r_d = '0;   duty_g_d = IVal; duty_b_d = rise; end
      StPh3: begin duty_r_d = '0;   duty_g_d = fall; duty_b_d = IVal; end
      StPh4: begin duty_r_d = rise; duty_g_d = '0;   duty_b_d = IVal; end
      StPh5: begin duty_r_d = IVal; duty_g_d = '0;   duty_b_d = fall; end
      default: begin
        duty_r_d = IVal;
        duty_g_d = '0;
        duty_b_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      phase_q   <= StPh0;
      ramp_q    <= '0;
      duty_r_q  <= IVal;
      duty_g_q  <= '0;
      duty_b_q  <= '0;
      rgb_r_q   <= 1'b0;
      rgb_g_q   <= 1'b0;
      rgb_b_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= period_tick ? '0 : pwm_cnt_q + CW'(1);
      phase_q   <= phase_d;
      ramp_q    <= ramp_d;
      if (period_tick) begin
        duty_r_q <= duty_r_d;
        duty_g_q <= duty_g_d;
        duty_b_q <= duty_b_d;
      end
      // Compare uses the pre-edge count and duty, giving one cycle of latency.
      rgb_r_q <= (pwm_cnt_q < duty_r_q);
      rgb_g_q <= (pwm_cnt_q < duty_g_q);
      rgb_b_q <= (pwm_cnt_q < duty_b_q);
    end
  end

  assign bus.RGB_R       = rgb_r_q;
  assign bus.RGB_G       = rgb_g_q;
  assign bus.RGB_B       = rgb_b_q;
  assign bus.phase       = phase_q;
  assign bus.period_tick = period_tick;

endmodule

// File: doc/color_wheel_sequencer.md
Name: color_wheel_sequencer

Overview:
- Generates three PWM channels (red, green, blue) and sequences their duty cycles around a six-phase HSV hue wheel.
- Replaces the free-running color logic inside the LED top level; top instantiates it and maps outputs to the RGB pins, handling any pin inversion there.
- Contains one shared PWM period counter and a phase/ramp state machine.
- Duty changes are applied only at PWM period boundaries, so output pulses never glitch.

Parameters:
- PWM_INTERVAL, 1200: clocks per PWM period (100 us at 12 MHz); must be ≥ 2.
- DUTY_STEP, 12: duty increment per PWM period in clocks; PWM_INTERVAL % DUTY_STEP must be 0 (checked by elaboration assertion).
- Derived CW = $clog2(PWM_INTERVAL+1): width of counter, ramp and duty registers.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  1 = wheel advances; 0 = hue frozen, PWM keeps running
- RGB_R  out  1  red PWM, active-high, registered
- RGB_G  out  1  green PWM, active-high, registered
- RGB_B  out  1  blue PWM, active-high, registered
- phase  out  3  current hue phase 0..5
- period_tick  out  1  one-cycle pulse in the last clock of each PWM period

Behaviour:
- pwm_cnt counts 0..PWM_INTERVAL-1, then wraps to 0; it runs regardless of en.
- period_tick is combinational: it equals (pwm_cnt == PWM_INTERVAL-1).
- Each channel output is registered: at every edge, out <= (pwm_cnt < duty_x), using pre-edge values. This gives one cycle of latency.
  - duty 0 gives a constant low.
  - duty PWM_INTERVAL gives a constant high.
- ramp takes values 0, S, 2S … I-S, where S = DUTY_STEP and I = PWM_INTERVAL.
- At period end (period_tick) with en=1:
  - If ramp == I-S: ramp <= 0 and phase advances (5 wraps to 0).
  - Otherwise: ramp <= ramp+S.
- At period end with en=0, ramp and phase hold.
- duty_r/g/b are registered at period end from the next-state phase and ramp, so new duties take effect when pwm_cnt==0.
- Duty per phase (rise = ramp, fall = I-ramp):
  - phase 0: R=I, G=rise, B=0
  - phase 1: R=fall, G=I, B=0
  - phase 2: R=0, G=I, B=rise
  - phase 3: R=0, G=fall, B=I
  - phase 4: R=rise, G=0, B=I
  - phase 5: R=I, G=0, B=fall
- Phase transitions are continuous: the rising channel ends at I-S and the next phase holds it at I.
- Wheel length is 6·I/S PWM periods.
- phase values 6 and 7 are unreachable; if ever present, the next period end forces phase 0 with ramp 0.
- Reset, synchronous, takes priority over everything, including mid-period:
  - pwm_cnt=0, phase=0, ramp=0
  - duty_r=I, duty_g=0, duty_b=0
  - RGB_R/G/B=0
- First cycle after reset release: outputs still 0. From the second cycle, RGB_R is high for the full period.
- Arithmetic is unsigned CW-bit. No overflow is possible because ramp ≤ I-S and fall ≥ S.

Test Plan (PWM_INTERVAL=12, DUTY_STEP=4: 3 periods per phase, 18 periods / 216 clocks per wheel):
- Reset: hold rst 3 cycles, then release → outputs 0 and phase=0 during reset. Period 0: RGB_R high 12/12 cycles, G and B 0/12. period_tick pulses every 12th cycle.
- Ramp: en=1 → G high-count per period is 0, 4, 8. Period 3: phase=1 with R=12, G=12. Period 4: R=8, G=12. Period 5: R=4.
- Wrap: run 18 periods → phase sequence 0,1,2,3,4,5 then back to 0, with duties (12,0,0) again. Continuity check: no channel jumps by more than 4 between consecutive periods.
- Freeze: drop en for 5 periods during phase 2 with B=4 → B stays high 4/12 in each of those periods and phase stays 2. Raising en resumes at B=8.
- Mid-period reset: assert rst at pwm_cnt=7 in phase 3 → all outputs 0 on the next cycle and phase=0. Sequence restarts exactly as in the reset scenario.
- Boundary glitch: en toggled at period_tick cycle → no output pulse shorter or longer than the programmed duty. A duty change is never visible before pwm_cnt==0.
